vowel_scanner: RTL

VOWEL_SCANNER -- requirements
Module: vowel_scanner

---
 rtl/vowel_scanner_pkg.sv | 29 ++
 rtl/vowel_scanner_detect.sv | 36 +++
 rtl/vowel_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vowel_scanner_pkg.sv
// rtl/vowel_scanner_pkg.sv - shared constants and FSM encoding for the vowel scanner
// Contents: ASCII vowel codes (lower and upper case), ASCII letter range bounds,
//           and the scanner FSM state type.
package vowel_scanner_pkg;

  localparam logic [7:0] CH_LO_A = 8'h61;
  localparam logic [7:0] CH_LO_E = 8'h65;
  localparam logic [7:0] CH_LO_I = 8'h69;
  localparam logic [7:0] CH_LO_O = 8'h6F;
  localparam logic [7:0] CH_LO_U = 8'h75;

  localparam logic [7:0] CH_UP_A = 8'h41;
  localparam logic [7:0] CH_UP_E = 8'h45;
  localparam logic [7:0] CH_UP_I = 8'h49;
  localparam logic [7:0] CH_UP_O = 8'h4F;
  localparam logic [7:0] CH_UP_U = 8'h55;

  localparam logic [7:0] LETTER_UP_MIN = 8'h41;  // 'A'
  localparam logic [7:0] LETTER_UP_MAX = 8'h5A;  // 'Z'
  localparam logic [7:0] LETTER_LO_MIN = 8'h61;  // 'a'
  localparam logic [7:0] LETTER_LO_MAX = 8'h7A;  // 'z'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/vowel_scanner_detect.sv
// rtl/vowel_scanner_detect.sv - combinational character classifier (module vowel_detect)
// Configuration macro: VOWEL_UPPERCASE_EN - when defined, uppercase A/E/I/O/U also count as vowels.
// Ports:
//   data      in  DATA_W : character to classify
//   is_vowel  out 1      : character is a vowel
//   is_letter out 1      : character is an ASCII letter A-Z or a-z
module vowel_detect
  import vowel_scanner_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              is_vowel,
  output logic              is_letter
);

  logic lo_vowel;
  logic up_vowel;

  always_comb begin
    lo_vowel = (data == DATA_W'(CH_LO_A)) || (data == DATA_W'(CH_LO_E)) ||
               (data == DATA_W'(CH_LO_I)) || (data == DATA_W'(CH_LO_O)) ||
               (data == DATA_W'(CH_LO_U));
    up_vowel = (data == DATA_W'(CH_UP_A)) || (data == DATA_W'(CH_UP_E)) ||
               (data == DATA_W'(CH_UP_I)) || (data == DATA_W'(CH_UP_O)) ||
               (data == DATA_W'(CH_UP_U));
    is_letter = ((data >= DATA_W'(LETTER_UP_MIN)) && (data <= DATA_W'(LETTER_UP_MAX))) ||
                ((data >= DATA_W'(LETTER_LO_MIN)) && (data <= DATA_W'(LETTER_LO_MAX)));
`ifdef VOWEL_UPPERCASE_EN
    is_vowel = lo_vowel || up_vowel;
`else
    is_vowel = lo_vowel;
`endif
  end

endmodule

// File: rtl/vowel_scanner.sv
// rtl/vowel_scanner.sv - scans a password held in a read-only RAM, counting vowels and letters
// Ports:
//   clock        in  1        : clock, rising edge
//   reset        in  1        : asynchronous active-high reset
//   start        in  1        : begin a scan (ignored while busy)
//   length       in  ADDR_W+1 : characters to scan, clamped to 2**ADDR_W
//   ram_addr     out ADDR_W   : RAM read address
//   ram_rdata    in  DATA_W   : combinational RAM read data
//   busy         out 1        : scan in progress (SCAN or FIN)
//   done         out 1        : one-cycle completion pulse
//   vowel_count  out ADDR_W+1 : vowels found in the last scan
//   letter_count out ADDR_W+1 : letters found in the last scan
// Uppercase vowel handling is selected by VOWEL_UPPERCASE_EN inside vowel_detect.
module vowel_scanner
  import vowel_scanner_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   vowel_count,
  output logic [ADDR_W:0]   letter_count
);

  localparam int             CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(2 ** ADDR_W);

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    len_q,    len_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [CNT_W-1:0]    vowel_q,  vowel_d;
  logic [CNT_W-1:0]    letter_q, letter_d;
  logic                done_q,   done_d;

  logic                is_vowel;
  logic                is_letter;
  logic                last_entry;
  logic [CNT_W-1:0]    len_clamped;

  vowel_detect #(.DATA_W(DATA_W)) u_detect (
    .data      (ram_rdata),
    .is_vowel  (is_vowel),
    .is_letter (is_letter)
  );

  // len_q is never 0 while in SCAN, so len_q-1 cannot underflow there.
  assign last_entry  = ({1'b0, addr_q} == (len_q - CNT_W'(1)));
  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      addr_q   <= '0;
      vowel_q  <= '0;
      letter_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      vowel_q  <= vowel_d;
      letter_q <= letter_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (length == '0) ? ST_FIN : ST_SCAN;
      ST_SCAN: if (last_entry) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // done is registered from FIN so the pulse lands one cycle after FIN,
  // giving the start-to-done latency of N+1 edges.
  always_comb begin
    busy   = (state_q != ST_IDLE);
    done_d = (state_q == ST_FIN);
  end

  always_comb begin
    len_d    = len_q;
    addr_d   = addr_q;
    vowel_d  = vowel_q;
    letter_d = letter_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) begin
          len_d    = len_clamped;
          vowel_d  = '0;
          letter_d = '0;
        end
      end
      ST_SCAN: begin
        if (is_vowel && (vowel_q != MAX_LEN))
          vowel_d = vowel_q + CNT_W'(1);
        if (is_letter && (letter_q != MAX_LEN))
          letter_d = letter_q + CNT_W'(1);
        // Hold on the last entry so the address never wraps past 2**ADDR_W-1.
        if (!last_entry)
          addr_d = addr_q + ADDR_W'(1);
      end
      ST_FIN:  addr_d = '0;
      default: addr_d = '0;
    endcase
  end

  assign ram_addr     = addr_q;
  assign done         = done_q;
  assign vowel_count  = vowel_q;
  assign letter_count = letter_q;

endmodule
